round_robin_grant_dec: RTL and testbench
========================================

# round_robin_grant_dec

Receiving end of the round-robin performance encoder's grant output. It takes the encoder's valid/binary-index grant stream and decodes it to a registered one-hot grant. It checks every grant against the request vector the grant was computed from. It keeps per-channel grant statistics and flags any channel starved beyond a fixed limit, so arbiter fairness can be monitored in-system and in simulation.

## Interface
- WIDTH, 8: number of channels; any value ≥2, power of two not required.
- WIDTH_W, $clog2(WIDTH): width of the binary grant index.
- CNT_W, 16: width of each per-channel grant counter.
- STARVE_LIMIT, 2*WIDTH: waiting cycles (≥1) that mark a requesting channel as starved.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  WIDTH  request vector that the encoder arbitrated this cycle; the integrator aligns it with id_*.
- id_valid  in  1  grant present this cycle.
- id_bin  in  WIDTH_W  binary index of the granted channel.
- cnt_clr  in  1  synchronous clear of all counters and starve flags.
- cnt_sel  in  WIDTH_W  selects the channel shown on cnt_out.
- od_valid  out  1  registered copy of id_valid.
- od_pos  out  WIDTH  registered one-hot grant; all zero when od_valid=0.
- od_err  out  1  registered flag: the grant was illegal.
- starve  out  WIDTH  sticky per-channel starvation flags.
- cnt_out  out  CNT_W  registered grant count of the channel on cnt_sel.

## Operation
- Reset values: od_valid=0, od_pos=0, od_err=0, starve=0, cnt_out=0. All grant counters and wait counters are 0.
- Decode:
  - When id_valid=1 and id_bin<WIDTH, od_pos gets bit id_bin set and od_valid=1.
  - When id_bin≥WIDTH, od_pos=0, od_valid=1 and od_err=1.
- Legality: a grant with id_valid=1 is illegal when id_bin≥WIDTH or when req[id_bin]=0. od_err is valid only for the cycle of its grant and is 0 when id_valid=0.
- Grant counter i increments on each legal grant to channel i and saturates at 2^CNT_W-1. Illegal grants are not counted.
- Wait counter i:
  - Cleared when req[i]=0 or when a legal grant goes to i.
  - Otherwise increments each cycle and saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, starve[i] sets and stays set until cnt_clr or rst.
- cnt_clr=1 zeroes all grant counters, wait counters and starve flags on the next edge. cnt_clr overrides a same-cycle increment: the counter becomes 0, not 1. od_valid, od_pos and od_err are unaffected by cnt_clr.
- cnt_sel≥WIDTH gives cnt_out=0.
- rst mid-operation returns everything to its reset value immediately. No grant is counted across the reset edge.

## Timing
- od_valid, od_pos and od_err have a latency of 1 cycle from id_*.
- Back-to-back grants are accepted every cycle with no stalls and no backpressure.
- Grant counter: count is visible on cnt_out 2 cycles after the grant (1 cycle to update the counter, 1 cycle for the cnt_out register).
- cnt_sel change appears on cnt_out 1 cycle later.
- starve[i] sets on the edge where wait counter i reaches STARVE_LIMIT, i.e. STARVE_LIMIT cycles after req[i] first seen high with no grant to i.

## Test plan
- Reset then idle: req=0, id_valid=0 for 20 cycles → all outputs 0, od_pos=0.
- Legal sweep: req=8'hFF, id_bin=0..7 on consecutive cycles → od_pos=8'h01..8'h80 each one cycle later, od_err=0. Each count reads 1 via cnt_sel=0..7.
- Illegal grant: req=8'h04, id_valid=1, id_bin=3 → next cycle od_pos=8'h08, od_err=1. Channel 3 count stays 0.
- Starvation: req=8'h01, only channel 1 granted, STARVE_LIMIT=16 → starve=8'h01 exactly 16 cycles after req rises. It stays set after req drops. cnt_clr=1 clears it next edge.
- Saturation and clr priority: CNT_W=4, 20 legal grants to channel 2 → cnt_out=15. Grant plus cnt_clr in the same cycle → cnt_out=0.
- Random traffic from the encoder with mid-run rst pulse → od_err never 1. Counts match the scoreboard. All counters are 0 right after rst.

Source files
------------

// File: rtl/round_robin_grant_dec.sv
// round_robin_grant_dec
//
// Receiving side of the round-robin encoder's grant stream. Decodes the
// binary grant index to a registered one-hot grant, flags grants that are
// illegal with respect to the request vector they were computed from, keeps
// a saturating grant counter per channel and raises sticky starvation flags
// for channels that request for too long without being granted.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   req       in   [WIDTH]    request vector aligned with id_*
//   id_valid  in   grant present this cycle
//   id_bin    in   [WIDTH_W]  binary index of the granted channel
//   cnt_clr   in   synchronous clear of grant/wait counters and starve flags
//   cnt_sel   in   [WIDTH_W]  channel shown on cnt_out
//   od_valid  out  registered id_valid
//   od_pos    out  [WIDTH]    registered one-hot grant (zero when idle or
//                             when the index is out of range)
//   od_err    out  registered illegal-grant flag
//   starve    out  [WIDTH]    sticky per-channel starvation flags
//   cnt_out   out  [CNT_W]    registered grant count of channel cnt_sel
//
// Handshake: id_valid qualifies id_bin for exactly one cycle; there is no
// ready/backpressure, a grant is accepted on every cycle id_valid is high.
module round_robin_grant_dec #(
  parameter int WIDTH        = 8,
  parameter int WIDTH_W      = $clog2(WIDTH),
  parameter int CNT_W        = 16,
  parameter int STARVE_LIMIT = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   req,
  input  logic               id_valid,
  input  logic [WIDTH_W-1:0] id_bin,
  input  logic               cnt_clr,
  input  logic [WIDTH_W-1:0] cnt_sel,
  output logic               od_valid,
  output logic [WIDTH-1:0]   od_pos,
  output logic               od_err,
  output logic [WIDTH-1:0]   starve,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic               od_valid_q, od_valid_d;
  logic [WIDTH-1:0]   od_pos_q,   od_pos_d;
  logic               od_err_q,   od_err_d;
  logic [WIDTH-1:0]   starve_q,   starve_d;
  logic [CNT_W-1:0]   cnt_out_q,  cnt_out_d;
  logic [CNT_W-1:0]   cnt_q  [WIDTH];
  logic [CNT_W-1:0]   cnt_d  [WIDTH];
  logic [WAIT_W-1:0]  wait_q [WIDTH];
  logic [WAIT_W-1:0]  wait_d [WIDTH];

  logic [31:0]        bin_ext;
  logic               bin_in_range;
  logic [WIDTH-1:0]   gnt_oh;
  logic [WIDTH-1:0]   legal_vec;

  // Out-of-range indices decode to an all-zero vector, so a single AND with
  // req covers both illegal cases (bad index and unrequested channel).
  assign bin_ext      = 32'(id_bin);
  assign bin_in_range = (bin_ext < 32'(WIDTH));
  assign gnt_oh       = bin_in_range ? (WIDTH'(1) << id_bin) : '0;
  assign legal_vec    = id_valid ? (gnt_oh & req) : '0;

  always_comb begin
    od_valid_d = id_valid;
    od_pos_d   = id_valid ? gnt_oh : '0;
    od_err_d   = id_valid && (legal_vec == '0);
    starve_d   = starve_q;
    cnt_out_d  = '0;

    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]  = cnt_q[i];
      wait_d[i] = wait_q[i];

      if (cnt_clr) begin
        cnt_d[i]    = '0;
        wait_d[i]   = '0;
        starve_d[i] = 1'b0;
      end else begin
        if (legal_vec[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end

        if (!req[i] || legal_vec[i]) begin
          wait_d[i] = '0;
        end else if (wait_q[i] != WAIT_MAX) begin
          wait_d[i] = wait_q[i] + WAIT_W'(1);
        end

        // Sets on the same edge the wait counter reaches the limit.
        if (wait_d[i] == WAIT_MAX) begin
          starve_d[i] = 1'b1;
        end
      end

      // Registered view of the pre-update count; unmatched selects give 0.
      if (cnt_sel == WIDTH_W'(i)) begin
        cnt_out_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      od_valid_q <= 1'b0;
      od_pos_q   <= '0;
      od_err_q   <= 1'b0;
      starve_q   <= '0;
      cnt_out_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]  <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      od_valid_q <= od_valid_d;
      od_pos_q   <= od_pos_d;
      od_err_q   <= od_err_d;
      starve_q   <= starve_d;
      cnt_out_q  <= cnt_out_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign od_valid = od_valid_q;
  assign od_pos   = od_pos_q;
  assign od_err   = od_err_q;
  assign starve   = starve_q;
  assign cnt_out  = cnt_out_q;

endmodule

// File: tb/tb_round_robin_grant_dec.sv
// Bench for round_robin_grant_dec: an 8-channel instance with 4-bit counters
// checked every cycle against a behavioural model, plus a 5-channel instance
// used to reach grant indices beyond WIDTH.
module tb_round_robin_grant_dec;

  localparam int W   = 8;
  localparam int WW  = 3;
  localparam int CW  = 4;
  localparam int LIM = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic [W-1:0]  req      = '0;
  logic          id_valid = 1'b0;
  logic [WW-1:0] id_bin   = '0;
  logic          cnt_clr  = 1'b0;
  logic [WW-1:0] cnt_sel  = '0;
  logic          od_valid;
  logic [W-1:0]  od_pos;
  logic          od_err;
  logic [W-1:0]  starve;
  logic [CW-1:0] cnt_out;

  round_robin_grant_dec #(.WIDTH(W), .CNT_W(CW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .req(req), .id_valid(id_valid), .id_bin(id_bin),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .od_valid(od_valid), .od_pos(od_pos),
    .od_err(od_err), .starve(starve), .cnt_out(cnt_out)
  );

  // 5-channel instance (index width 3, so indices 5..7 are out of range)
  logic [4:0]    b_req   = '0;
  logic          b_valid = 1'b0;
  logic [2:0]    b_bin   = '0;
  logic          b_clr   = 1'b0;
  logic [2:0]    b_sel   = '0;
  logic          b_od_valid;
  logic [4:0]    b_od_pos;
  logic          b_od_err;
  logic [4:0]    b_starve;
  logic [CW-1:0] b_cnt_out;

  round_robin_grant_dec #(.WIDTH(5), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .id_valid(b_valid), .id_bin(b_bin),
    .cnt_clr(b_clr), .cnt_sel(b_sel), .od_valid(b_od_valid), .od_pos(b_od_pos),
    .od_err(b_od_err), .starve(b_starve), .cnt_out(b_cnt_out)
  );

  // scoreboard and model state
  int total = 0;
  int bad   = 0;
  logic [9:0]    exp_q[$];
  logic [CW-1:0] m_cnt  [W];
  int            m_wait [W];
  logic [W-1:0]  m_starve;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < W; i++) begin
      m_cnt[i]  = '0;
      m_wait[i] = 0;
    end
    m_starve = '0;
  endtask

  // One clock of stimulus on the 8-channel instance, checked after the edge.
  task automatic step(input logic [W-1:0] r, input logic v, input logic [WW-1:0] b,
                      input logic clr, input logic [WW-1:0] sel);
    logic [W-1:0]  e_pos;
    logic          e_err;
    logic          legal;
    logic [CW-1:0] e_cnt;
    logic [9:0]    got;
    @(negedge clk);
    req = r; id_valid = v; id_bin = b; cnt_clr = clr; cnt_sel = sel;
    legal = v && r[b];
    e_pos = v ? (8'h01 << b) : 8'h00;
    e_err = v && !r[b];
    exp_q.push_back({v, e_pos, e_err});
    e_cnt = m_cnt[sel];
    for (int i = 0; i < W; i++) begin
      if (clr) begin
        m_cnt[i] = '0; m_wait[i] = 0; m_starve[i] = 1'b0;
      end else begin
        if (legal && (b == WW'(i)) && (m_cnt[i] != 4'd15)) m_cnt[i] = m_cnt[i] + 4'd1;
        if (!r[i] || (legal && (b == WW'(i)))) m_wait[i] = 0;
        else if (m_wait[i] < LIM) m_wait[i] = m_wait[i] + 1;
        if (m_wait[i] == LIM) m_starve[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    got = {od_valid, od_pos, od_err};
    check_eq("od", 32'(got), 32'(exp_q.pop_front()));
    check_eq("cnt_out", 32'(cnt_out), 32'(e_cnt));
    check_eq("starve", 32'(starve), 32'(m_starve));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; id_valid = 1'b0; id_bin = '0; cnt_clr = 1'b0; cnt_sel = '0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_od_valid", 32'(od_valid), 0);
    check_eq("rst_od_pos", 32'(od_pos), 0);
    check_eq("rst_od_err", 32'(od_err), 0);
    check_eq("rst_starve", 32'(starve), 0);
    check_eq("rst_cnt_out", 32'(cnt_out), 0);
    model_clear();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  r;
    logic [WW-1:0] b;
    logic          v;
    model_clear();

    // reset then idle
    do_reset();
    for (int k = 0; k < 20; k++) step('0, 1'b0, '0, 1'b0, '0);
    check_eq("idle_pos", 32'(od_pos), 0);

    // out-of-range indices on the 5-channel instance
    @(negedge clk); b_req = 5'h1F; b_valid = 1'b1; b_bin = 3'd6;
    @(posedge clk); #1;
    check_eq("b_oor_valid", 32'(b_od_valid), 1);
    check_eq("b_oor_pos", 32'(b_od_pos), 0);
    check_eq("b_oor_err", 32'(b_od_err), 1);
    @(negedge clk); b_bin = 3'd4;
    @(posedge clk); #1;
    check_eq("b_legal_pos", 32'(b_od_pos), 32'h10);
    check_eq("b_legal_err", 32'(b_od_err), 0);
    @(negedge clk); b_valid = 1'b0; b_req = '0; b_sel = 3'd4;
    @(posedge clk); #1;
    check_eq("b_idle_err", 32'(b_od_err), 0);
    check_eq("b_cnt4", 32'(b_cnt_out), 1);
    @(negedge clk); b_sel = 3'd6;
    @(posedge clk); #1;
    check_eq("b_cnt_oor_sel", 32'(b_cnt_out), 0);

    // legal sweep
    for (int i = 0; i < W; i++) begin
      step(8'hFF, 1'b1, WW'(i), 1'b0, '0);
      check_eq("sweep_pos", 32'(od_pos), 32'h1 << i);
      check_eq("sweep_err", 32'(od_err), 0);
    end
    for (int i = 0; i < W; i++) begin
      step('0, 1'b0, '0, 1'b0, WW'(i));
      check_eq("sweep_cnt", 32'(cnt_out), 1);
    end

    // illegal grant
    step('0, 1'b0, '0, 1'b1, '0);
    step(8'h04, 1'b1, 3'd3, 1'b0, 3'd3);
    check_eq("illegal_pos", 32'(od_pos), 32'h08);
    check_eq("illegal_err", 32'(od_err), 1);
    step('0, 1'b0, '0, 1'b0, 3'd3);
    step('0, 1'b0, '0, 1'b0, 3'd3);
    check_eq("illegal_cnt3", 32'(cnt_out), 0);

    // starvation of channel 0 while channel 1 is granted
    step('0, 1'b0, '0, 1'b1, '0);
    for (int k = 1; k <= LIM; k++) begin
      step(8'h01, 1'b1, 3'd1, 1'b0, '0);
      if (k == LIM - 1) check_eq("starve_early", 32'(starve), 0);
      if (k == LIM)     check_eq("starve_set", 32'(starve), 32'h01);
    end
    for (int k = 0; k < 3; k++) step('0, 1'b0, '0, 1'b0, '0);
    check_eq("starve_sticky", 32'(starve), 32'h01);
    step('0, 1'b0, '0, 1'b1, '0);
    check_eq("starve_clr", 32'(starve), 0);

    // saturation and clear priority
    for (int k = 0; k < 20; k++) step(8'h04, 1'b1, 3'd2, 1'b0, 3'd2);
    step('0, 1'b0, '0, 1'b0, 3'd2);
    step('0, 1'b0, '0, 1'b0, 3'd2);
    check_eq("sat_cnt", 32'(cnt_out), 15);
    step(8'h04, 1'b1, 3'd2, 1'b1, 3'd2);
    step('0, 1'b0, '0, 1'b0, 3'd2);
    check_eq("clr_prio_cnt", 32'(cnt_out), 0);

    // random encoder-like traffic with a reset pulse in the middle
    for (int k = 0; k < 300; k++) begin
      if (k == 150) begin
        do_reset();
        for (int i = 0; i < W; i++) begin
          step('0, 1'b0, '0, 1'b0, WW'(i));
          check_eq("post_rst_cnt", 32'(cnt_out), 0);
        end
      end
      r = W'($urandom_range(0, 255));
      v = (r != '0) && ($urandom_range(0, 3) != 0);
      b = WW'($urandom_range(0, 7));
      if (v) while (!r[b]) b = WW'($urandom_range(0, 7));
      step(r, v, b, ($urandom_range(0, 63) == 0), WW'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
